imem_access_ctrl: RTL and testbench
===================================

// Module: imem_access_ctrl
// PURPOSE
//  Sequences all accesses to the byte-wide, single-port instruction memory and shares it between two requesters.
//  Requester 1 is the core fetch path, which reads 32-bit words; requester 2 is the program loader, which writes bytes.
//  Each word is assembled big-endian from 4 byte reads: the byte at addr is bits [31:24], the byte at addr+3 is bits [7:0].
//  Sits between the fetch stage / boot loader and the instruction memory array.
// PARAMETERS
//  ADDR_W     32  width of all address ports
//  MEM_BYTES  32  memory depth in bytes; an access at or beyond this is out of range
//  NOP_INSTR  32'h00000013  word returned on a fetch error (addi x0,x0,0)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  fetch_req_i    in   1       fetch request; held until fetch_ready_o=1
//  fetch_addr_i   in   ADDR_W  byte address of the word to fetch
//  fetch_ready_o  out  1       combinational; fetch accepted this cycle
//  fetch_valid_o  out  1       one-cycle pulse; fetch_instr_o/fetch_err_o valid
//  fetch_instr_o  out  32      assembled instruction; held until the next fetch completes
//  fetch_err_o    out  1       misaligned or out-of-range fetch; qualified by valid
//  load_req_i     in   1       byte-write request; held until load_ack_o=1
//  load_addr_i    in   ADDR_W  byte address to write
//  load_data_i    in   8       byte to write
//  load_ack_o     out  1       one-cycle pulse; write complete
//  load_err_o     out  1       out-of-range write (suppressed); qualified by ack
//  mem_addr_o     out  ADDR_W  byte address to memory
//  mem_we_o       out  1       memory write enable
//  mem_wdata_o    out  8       memory write data
//  mem_rdata_i    in   8       combinational read data for mem_addr_o
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer favours fetch. All outputs are 0, including fetch_instr_o.
//  Reset asserted mid-access aborts the access: no valid/ack is issued, and a partial word is discarded.
//  Requests are sampled only in IDLE. An accepted request always completes, even if the requester drops req afterwards.
//  FSM states IDLE, RD, WR:
//   IDLE:
//    - Only fetch requesting -> fetch granted.
//    - Only load requesting -> load granted.
//    - Both requesting -> round-robin: the requester not granted last time wins.
//    - Fetch grant: fetch_ready_o=1, latch the address, go to RD with beat=0.
//      If the fetch is misaligned (addr[1:0]!=0) or addr+3 >= MEM_BYTES:
//      no memory access, stay in IDLE, and next cycle pulse valid with err=1 and instr=NOP_INSTR.
//    - Load grant: latch addr/data, go to WR.
//   RD, beats 0..3:
//    - mem_addr_o = base+beat (ADDR_W arithmetic; range is pre-checked so no wrap occurs).
//    - Each beat shifts mem_rdata_i into the word: word = {word[23:0], rdata}.
//    - After beat 3 go to IDLE. On that same edge, fetch_instr_o updates and fetch_valid_o=1 for the following cycle.
//   WR, 1 cycle:
//    - mem_we_o=1; mem_addr_o and mem_wdata_o take the latched values.
//    - load_ack_o=1. Go to IDLE.
//    - If addr >= MEM_BYTES: mem_we_o stays 0 and load_err_o=1.
//  Timing:
//   - Fetch latency: accept at cycle T, valid at T+5. A new grant is possible at T+5 (back-to-back fetch every 5 cycles).
//   - Load: accept at T, ack at T+1, next grant at T+2.
//   - A requester that holds req through the ack cycle is treated as making a new request.
//  Outputs when not in RD/WR: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
// STRUCTURE
//  Shared package imem_pkg holds:
//   - the state encoding (IDLE/RD/WR)
//   - BYTES_PER_WORD=4
//   - NOP_INSTR
//  Sub-module imem_rr_arb2: a 2-way round-robin arbiter.
//   - Inputs: req[1:0] and an advance strobe.
//   - Outputs: a one-hot gnt[1:0].
//   - The pointer updates only on advance.
// TESTING
//  1. Memory bytes 0..3 = 00,50,00,93; fetch addr 0 -> ready at T; mem_addr 0,1,2,3 on T+1..T+4; valid at T+5; instr=32'h00500093, err=0.
//  2. fetch_req and load_req both rising together from reset -> fetch granted first (5 cycles), then load;
//     with both held continuously, grants alternate fetch/load.
//  3. Fetch addr 32'h2 -> no mem access; valid next cycle with err=1, instr=32'h00000013.
//     Fetch addr 28 (MEM_BYTES=32) succeeds; fetch addr 30 errors.
//  4. Load addr 5, data 8'hA5 -> WR cycle with mem_we=1, addr=5, wdata=A5, ack=1;
//     a later fetch of addr 4 returns bits [23:16]=A5. Load addr 40 -> ack with err=1, mem_we never 1.
//  5. rst_n low during beat 2 -> next cycle: state IDLE, busy=0, valid never pulses, instr=0.
//     After release, a fetch works normally.
//  6. fetch_req dropped the cycle after ready -> fetch still completes with valid at T+5.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Holds the sequencer state encoding, the word geometry and the fetch-error filler word.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
// The priority pointer moves only when advance_i is high and something is granted.
module imem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // prio_q=0: requester 0 wins a tie, prio_q=1: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
    if (advance_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares a byte-wide single-port instruction memory between the fetch path (32-bit
// big-endian word reads, one byte per cycle) and the program loader (byte writes).
module imem_access_ctrl #(
  parameter int          ADDR_W    = 32,
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic              fetch_valid_o,
  output logic [31:0]       fetch_instr_o,
  output logic              fetch_err_o,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i,
  output logic              load_ack_o,
  output logic              load_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);
  import imem_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] laddr_q, laddr_d;
  logic [7:0]        ldata_q, ldata_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [1:0]        gnt;
  logic [ADDR_W:0]   fetch_last;
  logic              fetch_bad;
  logic              laddr_oob;

  // index 0 is fetch, index 1 is load; the pointer reset value favours fetch
  imem_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({load_req_i, fetch_req_i}),
    .advance_i (state_q == ST_IDLE),
    .gnt_o     (gnt)
  );

  // One extra bit so an address near the top of the space cannot wrap into range
  assign fetch_last = {1'b0, fetch_addr_i} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
  assign fetch_bad  = (fetch_addr_i[1:0] != 2'b00) ||
                      (fetch_last >= (ADDR_W+1)'(MEM_BYTES));
  assign laddr_oob  = laddr_q >= ADDR_W'(MEM_BYTES);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    word_d        = word_q;
    laddr_d       = laddr_q;
    ldata_d       = ldata_q;
    instr_d       = instr_q;
    valid_d       = 1'b0;
    err_d         = err_q;
    fetch_ready_o = 1'b0;
    load_ack_o    = 1'b0;
    load_err_o    = 1'b0;
    mem_addr_o    = '0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          fetch_ready_o = 1'b1;
          if (fetch_bad) begin
            // Rejected fetch never touches memory; answer with a NOP next cycle
            valid_d = 1'b1;
            err_d   = 1'b1;
            instr_d = NOP_INSTR;
          end else begin
            base_d  = fetch_addr_i;
            beat_d  = 2'd0;
            state_d = ST_RD;
          end
        end else if (gnt[1]) begin
          laddr_d = load_addr_i;
          ldata_d = load_data_i;
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        mem_addr_o = base_q + ADDR_W'(beat_q);
        word_d     = {word_q[15:0], mem_rdata_i};
        beat_d     = beat_q + 2'd1;
        if (beat_q == 2'(BYTES_PER_WORD - 1)) begin
          instr_d = {word_q, mem_rdata_i};
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        mem_addr_o  = laddr_q;
        mem_wdata_o = ldata_q;
        mem_we_o    = !laddr_oob;
        load_ack_o  = 1'b1;
        load_err_o  = laddr_oob;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      base_q  <= '0;
      word_q  <= '0;
      laddr_q <= '0;
      ldata_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      word_q  <= word_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign fetch_valid_o = valid_q;
  assign fetch_instr_o = instr_q;
  assign fetch_err_o   = err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: directed vector table, arbitration and
// reset corner sequences, then random traffic against a byte-array reference model.
module tb_imem_access_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_ready, fetch_valid, fetch_err;
  logic [31:0] fetch_addr, fetch_instr;
  logic        load_req, load_ack, load_err;
  logic [31:0] load_addr;
  logic [7:0]  load_data;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int we_oob = 0;

  logic       mem_init;
  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];

  always #5 clk = ~clk;

  imem_access_ctrl #(.ADDR_W(32), .MEM_BYTES(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
    .fetch_valid_o(fetch_valid), .fetch_instr_o(fetch_instr), .fetch_err_o(fetch_err),
    .load_req_i(load_req), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_ack_o(load_ack), .load_err_o(load_err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0, 2:    return 8'h00;
      1:       return 8'h50;
      3:       return 8'h93;
      default: return 8'(16 + i);
    endcase
  endfunction

  // Memory array behind the controller: combinational read, clocked write
  assign mem_rdata = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 8'h00;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_byte(i);
    end else if (mem_we && mem_addr < 32'd32) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (mem_we && mem_addr >= 32'd32) we_oob++;

  // Reference model: spec rules in plain arithmetic
  function automatic bit model_fetch_err(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) + 3 >= 32);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int ia = int'(a);
    return {ref_mem[ia], ref_mem[ia+1], ref_mem[ia+2], ref_mem[ia+3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input bit exp_err, input logic [31:0] exp_instr,
                          input string tag);
    bit got;
    int lat;
    logic [31:0] seen [4];
    for (int b = 0; b < 4; b++) seen[b] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = a;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fetch_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, ":ready"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;   // dropped right after acceptance; fetch must still complete
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= 4) seen[n-1] = mem_addr;
      if (fetch_valid) begin got = 1'b1; lat = n; break; end
      @(posedge clk); #1;
    end
    check({tag, ":valid"}, 32'(got), 32'd1);
    check({tag, ":latency"}, 32'(lat), exp_err ? 32'd1 : 32'd5);
    if (exp_err) begin
      check({tag, ":no_mem_access"}, seen[0], 32'd0);
    end else begin
      for (int b = 0; b < 4; b++)
        check($sformatf("%s:beat%0d_addr", tag, b), seen[b], a + 32'(b));
    end
    check({tag, ":err"}, 32'(fetch_err), 32'(exp_err));
    check({tag, ":instr"}, fetch_instr, exp_instr);
    $display("txn fetch addr=%h err=%0b instr=%h lat=%0d", a, fetch_err, fetch_instr, lat);
    @(negedge clk);
    check({tag, ":valid_pulse"}, 32'(fetch_valid), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [7:0] d, input bit exp_err,
                         input string tag);
    bit got;
    int lat;
    logic we_s, err_s;
    logic [31:0] addr_s;
    logic [7:0] wd_s;
    we_s = 1'bx; err_s = 1'bx; addr_s = 'x; wd_s = 'x;
    @(posedge clk); #1;
    load_req = 1'b1; load_addr = a; load_data = d;
    got = 1'b0; lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (load_ack) begin
        got = 1'b1; lat = n;
        we_s = mem_we; err_s = load_err; addr_s = mem_addr; wd_s = mem_wdata;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, ":ack"}, 32'(got), 32'd1);
    check({tag, ":ack_latency"}, 32'(lat), 32'd1);
    check({tag, ":we"}, 32'(we_s), 32'(!exp_err));
    check({tag, ":err"}, 32'(err_s), 32'(exp_err));
    check({tag, ":addr"}, addr_s, a);
    check({tag, ":wdata"}, 32'(wd_s), 32'(d));
    $display("txn load addr=%h data=%h err=%0b", a, d, err_s);
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    check({tag, ":ack_pulse"}, 32'(load_ack), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; fetch_req = 1'b0; load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [7:0]  data;
    bit          exp_err;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [15:0] rdy_v, val_v, ack_v, exp_rdy, exp_val, exp_ack;
    int t, nvalid;
    bit fetch_turn, idle_seen;

    vecs[0]  = '{1'b0, 32'd0,          8'h00, 1'b0, 32'h0050_0093};
    vecs[1]  = '{1'b0, 32'd2,          8'h00, 1'b1, NOP};
    vecs[2]  = '{1'b1, 32'd5,          8'hA5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'd4,          8'h00, 1'b0, 32'h14A5_1617};
    vecs[4]  = '{1'b0, 32'd28,         8'h00, 1'b0, 32'h2C2D_2E2F};
    vecs[5]  = '{1'b0, 32'd30,         8'h00, 1'b1, NOP};
    vecs[6]  = '{1'b1, 32'd40,         8'h3C, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'd31,         8'h5A, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'd28,         8'h00, 1'b0, 32'h2C2D_2E5A};
    vecs[9]  = '{1'b0, 32'd32,         8'h00, 1'b1, NOP};
    vecs[10] = '{1'b0, 32'd29,         8'h00, 1'b1, NOP};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC,  8'h00, 1'b1, NOP};

    for (int i = 0; i < 32; i++) ref_mem[i] = init_byte(i);
    rst_n = 1'b0; mem_init = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    load_req = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:busy",        32'(busy),        32'd0);
    check("rst:fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst:fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst:fetch_instr", fetch_instr,      32'd0);
    check("rst:fetch_err",   32'(fetch_err),   32'd0);
    check("rst:load_ack",    32'(load_ack),    32'd0);
    check("rst:load_err",    32'(load_err),    32'd0);
    check("rst:mem_we",      32'(mem_we),      32'd0);
    check("rst:mem_addr",    mem_addr,         32'd0);
    check("rst:mem_wdata",   32'(mem_wdata),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_init = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_load) begin
        do_load(vecs[i].addr, vecs[i].data, vecs[i].exp_err, $sformatf("vec%0d", i));
        if (!vecs[i].exp_err) ref_mem[int'(vecs[i].addr)] = vecs[i].data;
      end else begin
        do_fetch(vecs[i].addr, vecs[i].exp_err, vecs[i].exp_instr, $sformatf("vec%0d", i));
      end
    end

    // Both requesters rising together from reset and held: fetch first, then alternate
    apply_reset();
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    load_req = 1'b1; load_addr = 32'd6; load_data = 8'h77;
    rdy_v = '0; val_v = '0; ack_v = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rdy_v[c] = fetch_ready; val_v[c] = fetch_valid; ack_v[c] = load_ack;
      if (fetch_valid) check($sformatf("arb:instr_c%0d", c), fetch_instr, model_word(32'd0));
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; load_req = 1'b0;
    exp_rdy = '0; exp_val = '0; exp_ack = '0;
    t = 0; fetch_turn = 1'b1;
    while (t < 16) begin
      if (fetch_turn) begin
        exp_rdy[t] = 1'b1;
        if (t + 5 < 16) exp_val[t+5] = 1'b1;
        t += 5;
      end else begin
        if (t + 1 < 16) exp_ack[t+1] = 1'b1;
        t += 2;
      end
      fetch_turn = !fetch_turn;
    end
    check("arb:ready_cycles", 32'(rdy_v), 32'(exp_rdy));
    check("arb:valid_cycles", 32'(val_v), 32'(exp_val));
    check("arb:ack_cycles",   32'(ack_v), 32'(exp_ack));
    $display("txn arbitration ready=%h valid=%h ack=%h", rdy_v, val_v, ack_v);
    ref_mem[6] = 8'h77;
    idle_seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) begin idle_seen = 1'b1; break; end
    end
    check("arb:drain_idle", 32'(idle_seen), 32'd1);

    // Reset asserted during beat 2 aborts the fetch
    apply_reset();
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    check("rstmid:ready", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid:in_beat2", 32'(busy), 32'd1);
    rst_n = 1'b0;
    nvalid = 0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid:busy",  32'(busy),   32'd0);
    check("rstmid:instr", fetch_instr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (fetch_valid) nvalid++;
    end
    check("rstmid:no_valid", 32'(nvalid), 32'd0);
    check("rstmid:instr_after", fetch_instr, 32'd0);
    $display("txn reset during beat 2, valids seen=%0d", nvalid);
    do_fetch(32'd0, 1'b0, model_word(32'd0), "rstmid:refetch");

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [7:0]  d;
      if ($urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 40));
        d = 8'($urandom);
        do_load(a, d, a >= 32, $sformatf("rnd%0d", i));
        if (a < 32) ref_mem[int'(a)] = d;
      end else begin
        a = 32'($urandom_range(0, 36));
        if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
        if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC;
        do_fetch(a, model_fetch_err(a), model_fetch_err(a) ? NOP : model_word(a),
                 $sformatf("rnd%0d", i));
      end
    end

    check("mem_we_out_of_range", 32'(we_oob), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
